// File: rtl/branch_hazard_unit_pkg.sv
// Shared types and constants for the ID-stage branch hazard (stall/flush) controller.
package branch_hazard_unit_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT2_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [REG_W-1:0]  REG_ZERO       = 5'd0;
    localparam logic [CNT2_W-1:0] STALL_NONE     = 2'd0;
    localparam logic [CNT2_W-1:0] STALL_ALU      = 2'd1;
    localparam logic [CNT2_W-1:0] STALL_LOAD_EX  = 2'd2;
    localparam logic [CNT2_W-1:0] STALL_LOAD_MEM = 2'd1;
    localparam logic [CNT2_W-1:0] STALL_LOAD_USE = 2'd1;

endpackage

// File: rtl/branch_hazard_unit_hazard_match.sv
// One source-vs-destination comparison; $0 and non-writing producers never match.
module hazard_match
    import branch_hazard_unit_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] dst_i,
    input  logic             reg_write_i,
    input  logic             en_i,
    output logic             match_o
);

    assign match_o = en_i && reg_write_i && (src_i != REG_ZERO) && (src_i == dst_i);

endmodule

// File: rtl/branch_hazard_unit.sv
// Stall/flush controller for the ID-stage branch path: holds PC and IF/ID, bubbles ID/EX,
// and flushes IF/ID on a resolved taken branch or jump.
module branch_hazard_unit
    import branch_hazard_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ID_Branch,
    input  logic             ID_Jump,
    input  logic             ID_UsesRt,
    input  logic [REG_W-1:0] rs_ID,
    input  logic [REG_W-1:0] rt_ID,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_rd,
    input  logic             EX_MEM_RegWrite,
    input  logic             EX_MEM_MemRead,
    input  logic [REG_W-1:0] EX_MEM_rd,
    input  logic             BranchTaken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             Stalling,
    output logic [CNT_W-1:0] StallCount
);

    state_t              state_q, state_d;
    logic [CNT2_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [CNT2_W-1:0]   need_n;
    logic                rs_en, rt_en;
    logic                rs_ex, rt_ex, rs_mem, rt_mem;
    logic                ex_hit, mem_hit;
    logic                stall_raw, stall;

    // A jump carries no register operands, so rs is only examined for non-jumps or branches.
    assign rs_en = ID_Branch | ~ID_Jump;
    assign rt_en = ID_Branch | ID_UsesRt;

    hazard_match u_rs_ex  (.src_i(rs_ID), .dst_i(ID_EX_rd),  .reg_write_i(ID_EX_RegWrite),  .en_i(rs_en), .match_o(rs_ex));
    hazard_match u_rt_ex  (.src_i(rt_ID), .dst_i(ID_EX_rd),  .reg_write_i(ID_EX_RegWrite),  .en_i(rt_en), .match_o(rt_ex));
    hazard_match u_rs_mem (.src_i(rs_ID), .dst_i(EX_MEM_rd), .reg_write_i(EX_MEM_RegWrite), .en_i(rs_en), .match_o(rs_mem));
    hazard_match u_rt_mem (.src_i(rt_ID), .dst_i(EX_MEM_rd), .reg_write_i(EX_MEM_RegWrite), .en_i(rt_en), .match_o(rt_mem));

    assign ex_hit  = rs_ex | rt_ex;
    assign mem_hit = rs_mem | rt_mem;

    // Stall depth: branches compare in ID so need operands earlier than EX-stage consumers.
    always_comb begin
        need_n = STALL_NONE;
        if (ID_Branch) begin
            if (ex_hit) begin
                need_n = ID_EX_MemRead ? STALL_LOAD_EX : STALL_ALU;
            end else if (mem_hit && EX_MEM_MemRead) begin
                need_n = STALL_LOAD_MEM;
            end
        end else if (ex_hit && ID_EX_MemRead) begin
            need_n = STALL_LOAD_USE;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (need_n != STALL_NONE) begin
                    stall_raw = 1'b1;
                    cnt_d     = need_n - CNT2_W'(1);
                    if (need_n > CNT2_W'(1)) begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                stall_raw = 1'b1;
                cnt_d     = (cnt_q == '0) ? '0 : cnt_q - CNT2_W'(1);
                if (cnt_q <= CNT2_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall = stall_raw & ~Reset;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign PCWrite      = ~stall;
    assign IF_ID_Write  = ~stall;
    assign ID_EX_Bubble = stall;
    assign Stalling     = stall;
    assign IF_ID_Flush  = ~Reset & ~stall & ((ID_Branch & BranchTaken) | ID_Jump);
    assign StallCount   = stall_cnt_q;

endmodule

// File: doc/branch_hazard_unit.md
Name: branch_hazard_unit

Overview:
Stall and flush controller for the ID-stage branch path; it is the counterpart of the branch forwarding unit. The forwarding unit can only bypass ALU results that have reached EX/MEM. This block detects every branch or load-use operand that is not yet forwardable. It freezes PC and IF/ID for the required number of cycles and injects bubbles into ID/EX. Once operands are valid, it flushes IF/ID on a taken branch or jump. It sits beside the ID-stage comparator and drives the pipeline-register write enables.

Parameters:
CNT_W, 16, width of the saturating stall-cycle statistics counter

Ports:
Clk  input  1  pipeline clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
ID_Branch  input  1  branch instruction in ID (uses rs and rt in the ID comparator)
ID_Jump  input  1  jump instruction in ID (no register operands checked)
ID_UsesRt  input  1  ID instruction reads rt
rs_ID  input  5  rs address in ID
rt_ID  input  5  rt address in ID
ID_EX_RegWrite  input  1  instruction in EX writes a register
ID_EX_MemRead  input  1  instruction in EX is a load
ID_EX_rd  input  5  destination register of EX instruction
EX_MEM_RegWrite  input  1  instruction in MEM writes a register
EX_MEM_MemRead  input  1  instruction in MEM is a load
EX_MEM_rd  input  5  destination register of MEM instruction
BranchTaken  input  1  ID comparator result, valid only when not stalling
PCWrite  output  1  1 = PC updates
IF_ID_Write  output  1  1 = IF/ID latches
ID_EX_Bubble  output  1  1 = zero ID/EX control signals
IF_ID_Flush  output  1  1 = IF/ID loads a NOP next edge
Stalling  output  1  FSM in STALL or stall asserted this cycle
StallCount  output  CNT_W  total stall cycles since reset, saturating

Behaviour:
- Hazard match: a source register matches a destination only if the source address is nonzero, equals that destination, and the producer's RegWrite is 1. rt is checked only when ID_Branch or ID_UsesRt is 1.
- Required stall count N, computed in IDLE (maximum over all rules that apply):
  - Branch source matches ID_EX_rd with ID_EX_MemRead=0: N=1 (the result is then forwarded from EX/MEM).
  - Branch source matches ID_EX_rd with ID_EX_MemRead=1: N=2.
  - Branch source matches EX_MEM_rd with EX_MEM_MemRead=1: N=1.
  - Branch source matches EX_MEM_rd, non-load: N=0 (forwarding handles it).
  - Non-branch source matches ID_EX_rd with ID_EX_MemRead=1 (load-use): N=1.
  - Otherwise N=0.
- FSM states: IDLE and STALL; a 2-bit down-counter cnt.
  - IDLE with N>0: assert stall this same cycle; load cnt=N-1; go to STALL if N-1>0, else stay in IDLE.
  - STALL: assert stall; decrement cnt; return to IDLE when cnt reaches 0 at the edge.
  - Hazard inputs are ignored while in STALL.
- Stall asserted means: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, Stalling=1. Outputs are combinational from state, cnt and the detection logic (zero-latency).
- Flush: IF_ID_Flush=1 in a non-stall cycle when (ID_Branch and BranchTaken) or ID_Jump. BranchTaken is ignored during any stall cycle. Flush and stall are never asserted together.
- StallCount: increments on every edge where stall was asserted; holds at all-ones (no wrap).
- Reset (asynchronous, any time, including mid-STALL): state=IDLE, cnt=0, StallCount=0. While Reset=1, outputs are forced to PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0, Stalling=0.
- Destination register $0 never causes a stall.

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, STALL=1'b1); constant REG_ZERO=5'd0; stall-depth constants STALL_ALU=2'd1, STALL_LOAD_EX=2'd2, STALL_LOAD_MEM=2'd1.
- One natural sub-module: hazard_match. It takes a source address, destination address, RegWrite and enable, and returns the match bit. It is instantiated four times: rs/rt against ID_EX and against EX_MEM.

Test Plan:
- Branch rs_ID=5'd8 with ID_EX_rd=8, ID_EX_RegWrite=1, MemRead=0 -> exactly 1 cycle of PCWrite=0 and ID_EX_Bubble=1; then BranchTaken=1 -> IF_ID_Flush=1 for 1 cycle; StallCount=1.
- Branch rt_ID=5'd9 with ID_EX_rd=9, ID_EX_MemRead=1 -> 2 consecutive stall cycles, then normal operation; StallCount=2.
- Branch rs_ID=10 with EX_MEM_rd=10, EX_MEM_MemRead=0 -> no stall; with EX_MEM_MemRead=1 -> 1 stall.
- Non-branch (ID_UsesRt=1) rt_ID=11 against load in EX with ID_EX_rd=11 -> 1 stall. Same case with rd=0 -> no stall. Case with ID_UsesRt=0 -> no stall.
- Assert Reset for a partial cycle during the second cycle of a 2-cycle load stall -> immediate PCWrite=1, Stalling=0, StallCount=0; no residual stall after release.
- Force 2^CNT_W+3 stall cycles (CNT_W=4 build) -> StallCount saturates at 4'hF. BranchTaken=1 pulsed during a stall -> IF_ID_Flush stays 0.
